// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NREQ producers in the clk_w domain.
// Define FIFO_WR_ARB_STAT_EN to add the wr_words / full_stalls statistics outputs.
module fifo_wr_arbiter #(
   parameter int NREQ     = 4,
   parameter int DWIDTH   = 8,
   parameter int MAXBURST = 4,
   parameter int idsize   = 2
) (
   input  logic                     clk_w,
   input  logic                     rst_w,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DWIDTH-1:0]   din,
   input  logic                     full,
   output logic [NREQ-1:0]          ack,
   output logic                     wr_en,
   output logic [DWIDTH-1:0]        wdata,
   output logic [idsize-1:0]        owner,
   output logic                     busy
`ifdef FIFO_WR_ARB_STAT_EN
   ,
   output logic [31:0]              wr_words,
   output logic [31:0]              full_stalls
`endif
);

   localparam int CNTW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t              state_q, state_d;
   logic [idsize-1:0]   owner_q, owner_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic [idsize-1:0]   cand;
   logic                found;
   logic                own_req;
   logic                accept;
   logic                stall;
   logic [DWIDTH-1:0]   din_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign din_a[i] = din[i*DWIDTH +: DWIDTH];
   end

   assign own_req = req[owner_q];

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      found   = 1'b0;
      cand    = '0;
      accept  = 1'b0;
      stall   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Search starts just after the last owner, so it gets the lowest priority.
            for (int k = 1; k <= NREQ; k++) begin
               cand = idsize'((int'(owner_q) + k) % NREQ);
               if (!found && req[cand]) begin
                  found   = 1'b1;
                  owner_d = cand;
               end
            end
            if (found) begin
               state_d = S_BURST;
               cnt_d   = '0;
            end
         end
         S_BURST: begin
            accept = own_req & ~full;
            stall  = own_req & full;
            if (!own_req) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (!full) begin
               if (cnt_q == CNTW'(MAXBURST - 1)) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ack   = '0;
      wdata = '0;
      if (accept) ack[owner_q] = 1'b1;
      // Data follows the owner for the whole burst; the FIFO ignores it without wr_en.
      if (state_q == S_BURST) wdata = din_a[owner_q];
   end

   assign wr_en = accept;
   assign owner = owner_q;
   assign busy  = (state_q == S_BURST);

   always_ff @(posedge clk_w or negedge rst_w) begin
      if (!rst_w) begin
         state_q <= S_IDLE;
         owner_q <= idsize'(NREQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef FIFO_WR_ARB_STAT_EN
   logic [31:0] wr_words_q, wr_words_d;
   logic [31:0] full_stalls_q, full_stalls_d;

   always_comb begin
      wr_words_d    = wr_words_q;
      full_stalls_d = full_stalls_q;
      if (accept && !(&wr_words_q))   wr_words_d    = wr_words_q + 32'd1;
      if (stall && !(&full_stalls_q)) full_stalls_d = full_stalls_q + 32'd1;
   end

   always_ff @(posedge clk_w or negedge rst_w) begin
      if (!rst_w) begin
         wr_words_q    <= '0;
         full_stalls_q <= '0;
      end else begin
         wr_words_q    <= wr_words_d;
         full_stalls_q <= full_stalls_d;
      end
   end

   assign wr_words    = wr_words_q;
   assign full_stalls = full_stalls_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a grant/words-left reference model.
// Define FIFO_WR_ARB_STAT_EN to also check the statistics counters.
module tb_fifo_wr_arbiter;

   localparam int NREQ     = 4;
   localparam int DWIDTH   = 8;
   localparam int MAXBURST = 4;
   localparam int IDSIZE   = 2;

   logic                   clk_w = 1'b0;
   logic                   rst_w;
   logic [NREQ-1:0]        req;
   logic [NREQ*DWIDTH-1:0] din;
   logic                   full;
   logic [NREQ-1:0]        ack;
   logic                   wr_en;
   logic [DWIDTH-1:0]      wdata;
   logic [IDSIZE-1:0]      owner;
   logic                   busy;
`ifdef FIFO_WR_ARB_STAT_EN
   logic [31:0]            wr_words;
   logic [31:0]            full_stalls;
`endif

   fifo_wr_arbiter #(
      .NREQ(NREQ), .DWIDTH(DWIDTH), .MAXBURST(MAXBURST), .idsize(IDSIZE)
   ) dut (
      .clk_w(clk_w), .rst_w(rst_w), .req(req), .din(din), .full(full),
      .ack(ack), .wr_en(wr_en), .wdata(wdata), .owner(owner), .busy(busy)
`ifdef FIFO_WR_ARB_STAT_EN
      , .wr_words(wr_words), .full_stalls(full_stalls)
`endif
   );

   always #5 clk_w = ~clk_w;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: a grant is "who holds the port and how many words it may still write".
   bit     m_busy;
   int     m_owner;
   int     m_left;
   longint m_words;
   longint m_stalls;
   int     obs_wr;
   int     obs_busy;

   task automatic model_reset();
      m_busy   = 0;
      m_owner  = NREQ - 1;
      m_left   = 0;
      m_words  = 0;
      m_stalls = 0;
   endtask

   task automatic model_step();
      if (!m_busy) begin
         if (req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (req[(m_owner + k) % NREQ]) begin
                  m_owner = (m_owner + k) % NREQ;
                  break;
               end
            end
            m_busy = 1;
            m_left = MAXBURST;
         end
      end else if (!req[m_owner]) begin
         m_busy = 0;
      end else if (full) begin
         m_stalls++;
      end else begin
         m_words++;
         m_left--;
         if (m_left == 0) m_busy = 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [NREQ-1:0]   e_ack;
      logic [DWIDTH-1:0] e_wdata;
      logic              e_wr;
      e_wr    = m_busy && req[m_owner] && !full;
      e_ack   = '0;
      if (e_wr) e_ack[m_owner] = 1'b1;
      e_wdata = m_busy ? din[m_owner*DWIDTH +: DWIDTH] : '0;
      chk({tag, ".ack"},   64'(ack),   64'(e_ack));
      chk({tag, ".wr_en"}, 64'(wr_en), 64'(e_wr));
      chk({tag, ".wdata"}, 64'(wdata), 64'(e_wdata));
      chk({tag, ".busy"},  64'(busy),  64'(m_busy));
      chk({tag, ".owner"}, 64'(owner), 64'(m_owner));
   endtask

   task automatic tick(input string tag);
      @(negedge clk_w);
      check_outputs(tag);
      if (wr_en) obs_wr++;
      if (busy)  obs_busy++;
      model_step();
      @(posedge clk_w);
      #1;
      din = {$urandom, $urandom};
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".ack"},   64'(ack),   64'(0));
      chk({tag, ".wr_en"}, 64'(wr_en), 64'(0));
      chk({tag, ".wdata"}, 64'(wdata), 64'(0));
      chk({tag, ".busy"},  64'(busy),  64'(0));
      chk({tag, ".owner"}, 64'(owner), 64'(NREQ - 1));
   endtask

   task automatic check_stats(input string tag);
`ifdef FIFO_WR_ARB_STAT_EN
      chk({tag, ".wr_words"},    64'(wr_words),    64'(m_words));
      chk({tag, ".full_stalls"}, 64'(full_stalls), 64'(m_stalls));
`else
      chk({tag, ".model_sane"}, 64'(m_words >= 0), 64'(1));
`endif
   endtask

   initial begin
      int prev;
      rst_w = 1'b0;
      req   = '1;
      full  = 1'b0;
      din   = {$urandom, $urandom};
      model_reset();
      obs_wr = 0;
      obs_busy = 0;

      // Reset held with requests toggling.
      @(posedge clk_w); #1; req = '0;
      @(posedge clk_w); #1; req = '1;
      @(posedge clk_w); #1;
      check_reset_outputs("rst");
      rst_w = 1'b1;

      // All requesting, FIFO never full.
      tick("allreq");
      chk("first_owner", 64'(owner), 64'(0));
      for (int c = 1; c < 40; c++) tick("allreq");
      chk("allreq_writes", 64'(obs_wr), 64'(32));

      // Owner 1 drops its request after two words.
      for (int g = 0; g < 60 && !(m_busy && m_owner == 1 && m_left == MAXBURST - 2); g++)
         tick("drop");
      chk("drop_reach", 64'(m_busy && m_owner == 1 && m_left == MAXBURST - 2), 64'(1));
      req[1] = 1'b0;
      tick("drop");
      tick("drop");
      chk("drop_next_owner", 64'(owner), 64'(2));
      req = '1;

      // Full for five cycles after the second word of a burst.
      for (int g = 0; g < 60 && !(m_busy && m_left == MAXBURST - 2); g++) tick("stall");
      chk("stall_reach", 64'(m_busy && m_left == MAXBURST - 2), 64'(1));
      prev = m_owner;
      full = 1'b1;
      obs_wr = 0;
      obs_busy = 0;
      repeat (5) tick("stall");
      chk("stall_no_write", 64'(obs_wr), 64'(0));
      chk("stall_busy", 64'(obs_busy), 64'(5));
      full = 1'b0;
      obs_wr = 0;
      for (int g = 0; g < 10 && m_busy; g++) tick("stall");
      chk("stall_rest", 64'(obs_wr), 64'(2));
      tick("stall");
      chk("stall_rot", 64'(owner), 64'((prev + 1) % NREQ));

      // full and req[owner] drop together.
      for (int g = 0; g < 60 && !(m_busy && m_left == MAXBURST - 1); g++) tick("fdrop");
      chk("fdrop_reach", 64'(m_busy && m_left == MAXBURST - 1), 64'(1));
      full = 1'b1;
      req[m_owner] = 1'b0;
      obs_wr = 0;
      tick("fdrop");
      chk("fdrop_no_write", 64'(obs_wr), 64'(0));
      chk("fdrop_idle", 64'(busy), 64'(0));
      full = 1'b0;
      req  = '1;

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NREQ; i++) req[i] = ($urandom_range(3) != 0);
         full = ($urandom_range(3) == 0);
         tick("rand");
      end
      check_stats("stats");

      // Asynchronous reset with two words of a burst written.
      req  = '1;
      full = 1'b0;
      for (int g = 0; g < 60 && !(m_busy && m_left == MAXBURST - 2); g++) tick("arst");
      chk("arst_reach", 64'(m_busy && m_left == MAXBURST - 2), 64'(1));
      #2;
      rst_w = 1'b0;
      #1;
      check_reset_outputs("arst");
      model_reset();
      @(posedge clk_w); #1;
      check_reset_outputs("arst_hold");
      rst_w = 1'b1;
      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < NREQ; i++) req[i] = ($urandom_range(3) != 0);
         full = ($urandom_range(4) == 0);
         tick("post");
      end
      check_stats("stats_post");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
